// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - control/status bundle between the datapath control unit and pc_seq
interface pc_seq_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
);
    logic           clr;
    logic [W-1:0]   D;
    logic           wr;
    logic           inc;
    logic           conFFwr;
    logic           conFFen;
    logic           rel;
    logic           call;
    logic           ret;
    logic [W-1:0]   Q;
    logic [SPW-1:0] sp;
    logic           stk_full;
    logic           stk_empty;
    logic           stk_err;

    modport master (
        output clr, D, wr, inc, conFFwr, conFFen, rel, call, ret,
        input  Q, sp, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  clr, D, wr, inc, conFFwr, conFFen, rel, call, ret,
        output Q, sp, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with deferred increment and return-address stack
module pc_seq #(
    parameter int             W         = 32,
    parameter int             STEP      = 1,
    parameter logic [W-1:0]   RESET_VEC = '0,
    parameter int             DEPTH     = 4,
    parameter int             SPW       = $clog2(DEPTH + 1)
) (
    input  logic    clk,
    input  logic    clr_n,
    pc_seq_if.slave bus
);
    localparam int             AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W-1:0]   STEP_W = W'(STEP);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [W-1:0]   r_q;
    logic [SPW-1:0] r_sp;
    logic           r_err;
    logic           r_inc_pend;
    logic           r_wr_prev;
    logic [W-1:0]   r_stack [0:(2**AW)-1];

    logic           w_branch;
    logic           w_can_push;
    logic           w_can_pop;
    logic           w_push;
    logic [AW-1:0]  w_push_idx;
    logic [AW-1:0]  w_pop_idx;
    logic [W-1:0]   w_end_step;

    assign w_branch   = bus.conFFwr & bus.conFFen;
    assign w_can_push = (r_sp != SP_MAX);
    assign w_can_pop  = (r_sp != '0);
    assign w_push     = ~bus.clr & ~w_branch & ~bus.ret & bus.call & w_can_push;
    assign w_push_idx = r_sp[AW-1:0];
    assign w_pop_idx  = AW'(r_sp - 1'b1);

    // Step count at the end of a write: the deferred inc plus any inc arriving now.
    always_comb begin
        w_end_step = '0;
        case ({r_inc_pend, bus.inc})
            2'b11:   w_end_step = STEP_W << 1;
            2'b10,
            2'b01:   w_end_step = STEP_W;
            default: w_end_step = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q        <= RESET_VEC;
            r_sp       <= '0;
            r_err      <= 1'b0;
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (bus.clr) begin
            r_q        <= RESET_VEC;
            r_sp       <= '0;
            r_err      <= 1'b0;
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (w_branch) begin
            r_q        <= bus.D;
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (bus.ret) begin
            if (w_can_pop) begin
                r_q  <= r_stack[w_pop_idx];
                r_sp <= r_sp - 1'b1;
            end else begin
                r_err <= 1'b1;
            end
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (bus.call) begin
            if (w_can_push) begin
                r_q  <= bus.D;
                r_sp <= r_sp + 1'b1;
            end else begin
                r_err <= 1'b1;
            end
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (bus.wr) begin
            r_q       <= bus.D;
            r_wr_prev <= 1'b1;
            if (bus.inc) begin
                r_inc_pend <= 1'b1;
            end
        end else if (bus.rel) begin
            r_q        <= r_q + bus.D;
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (r_wr_prev) begin
            r_q        <= r_q + w_end_step;
            r_inc_pend <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else if (bus.inc) begin
            r_q <= r_q + STEP_W;
        end
    end

    // Stack contents are not reset; only sp defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= r_q + STEP_W;
        end
    end

    assign bus.Q         = r_q;
    assign bus.sp        = r_sp;
    assign bus.stk_full  = (r_sp == SP_MAX);
    assign bus.stk_empty = (r_sp == '0);
    assign bus.stk_err   = r_err;
endmodule
